// File: rtl/fetch_branch_ctrl_if.sv
// rtl/fetch_branch_ctrl_if.sv - PC / instruction memory / decode bundle for fetch_branch_ctrl
interface fetch_branch_ctrl_if #(
  parameter int AW    = 8,
  parameter int IW    = 16,
  parameter int CNT_W = 8
);
  logic [AW-1:0]    addr;
  logic             imem_rd_en;
  logic [AW-1:0]    imem_addr;
  logic [IW-1:0]    imem_data;
  logic             flag_zero;
  logic [IW-1:0]    instr_out;
  logic             instr_valid;
  logic             id_ready;
  logic             stop;
  logic             pc_wr;
  logic             if_ban;
  logic [AW-1:0]    jump;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    input  addr, imem_data, flag_zero, id_ready,
    output imem_rd_en, imem_addr, instr_out, instr_valid,
           stop, pc_wr, if_ban, jump, taken_cnt
  );

  modport slave (
    output addr, imem_data, flag_zero, id_ready,
    input  imem_rd_en, imem_addr, instr_out, instr_valid,
           stop, pc_wr, if_ban, jump, taken_cnt
  );
endinterface

// File: rtl/fetch_branch_ctrl.sv
// rtl/fetch_branch_ctrl.sv - fetch FSM resolving JMP/BEQ/BNE/HALT locally, issuing the rest to decode
module fetch_branch_ctrl #(
  parameter int AW    = 8,
  parameter int IW    = 16,
  parameter int CNT_W = 8
) (
  input logic          clk,
  input logic          rst,
  fetch_branch_ctrl_if.master bus
);
  typedef enum logic [2:0] {FETCH, WAIT, ISSUE, REDIRECT, HALTED} state_t;

  state_t     state;
  logic [3:0] opcode;
  logic       is_branch;
  logic       branch_taken;

  assign opcode       = bus.imem_data[IW-1 -: 4];
  assign is_branch    = (opcode == 4'hD) || (opcode == 4'hE);
  assign branch_taken = ((opcode == 4'hD) && bus.flag_zero) ||
                        ((opcode == 4'hE) && !bus.flag_zero);

  // The memory is synchronous, so the read strobe must be live in the FETCH cycle itself.
  assign bus.imem_rd_en = !rst && (state == FETCH);
  assign bus.imem_addr  = bus.addr;

  // stop reacts to id_ready and to the word being decoded, so it cannot wait a cycle.
  always_comb begin
    bus.stop = 1'b1;
    if (!rst) begin
      case (state)
        WAIT:     bus.stop = !(is_branch && !branch_taken);
        ISSUE:    bus.stop = !bus.id_ready;
        REDIRECT: bus.stop = 1'b0;
        default:  bus.stop = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= FETCH;
      bus.instr_out   <= '0;
      bus.instr_valid <= 1'b0;
      bus.pc_wr       <= 1'b0;
      bus.if_ban      <= 1'b0;
      bus.jump        <= '0;
      bus.taken_cnt   <= '0;
    end else begin
      case (state)
        FETCH: begin
          state <= WAIT;
        end
        WAIT: begin
          case (opcode)
            4'hC: begin
              state      <= REDIRECT;
              bus.pc_wr  <= 1'b1;
              bus.if_ban <= 1'b0;
              bus.jump   <= AW'(bus.imem_data[7:0]);
            end
            4'hD, 4'hE: begin
              if (branch_taken) begin
                state      <= REDIRECT;
                bus.pc_wr  <= 1'b1;
                bus.if_ban <= 1'b1;
                bus.jump   <= AW'(bus.imem_data[7:0]);
              end else begin
                state <= FETCH;
              end
            end
            4'hF: begin
              state <= HALTED;
            end
            default: begin
              state           <= ISSUE;
              bus.instr_out   <= bus.imem_data;
              bus.instr_valid <= 1'b1;
            end
          endcase
        end
        ISSUE: begin
          if (bus.id_ready) begin
            state           <= FETCH;
            bus.instr_valid <= 1'b0;
          end
        end
        REDIRECT: begin
          state     <= FETCH;
          bus.pc_wr <= 1'b0;
          if (bus.taken_cnt != {CNT_W{1'b1}})
            bus.taken_cnt <= bus.taken_cnt + 1'b1;
        end
        default: begin
          state <= HALTED;
        end
      endcase
    end
  end
endmodule
